// File: rtl/bch_serial_divider_pkg.sv
// GF(2^M) helpers shared by the serial divider: FSM encoding, primitive polynomials
// and the standard-basis arithmetic used by the inverter and the serial multiplier.
package bch_serial_divider_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    MUL   = 3'd4,
    DONE  = 3'd5
  } div_state_e;

  // Full primitive polynomial including the x^m term.
  function automatic logic [31:0] prim_poly(input int m);
    case (m)
      3:       return 32'h0000_000B;
      4:       return 32'h0000_0013;
      5:       return 32'h0000_0025;
      6:       return 32'h0000_0043;
      7:       return 32'h0000_0089;
      8:       return 32'h0000_011D;
      9:       return 32'h0000_0211;
      10:      return 32'h0000_0409;
      default: return 32'h0000_011D;
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input int m);
    return (32'd1 << m) - 32'd1;
  endfunction

  // Multiply by alpha: shift left and reduce by the primitive polynomial.
  function automatic logic [31:0] mulx(input int m, input logic [31:0] a);
    logic [31:0] r;
    r = a << 1;
    if (a[m-1]) begin
      r = r ^ prim_poly(m);
    end else begin
      r = r;
    end
    return r & field_mask(m);
  endfunction

  function automatic logic [31:0] gf_mul(input int m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      if (i < m) begin
        r = mulx(m, r);
        if (a[i]) r = r ^ b;
      end
    end
    return r;
  endfunction

  // a^(2^m - 2) as the product of a^(2^i), i = 1..m-1; maps 0 to 0.
  function automatic logic [31:0] gf_inv(input int m, input logic [31:0] a);
    logic [31:0] p;
    logic [31:0] r;
    p = a;
    r = 32'd1;
    for (int i = 1; i < 32; i++) begin
      if (i < m) begin
        p = gf_mul(m, p, p);
        r = gf_mul(m, r, p);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] lpow(input int m, input int i);
    logic [31:0] r;
    r = 32'd1;
    for (int k = 0; k < i; k++) r = mulx(m, r);
    return r;
  endfunction

  function automatic logic [31:0] brute_inverse(input int m, input logic [31:0] a);
    for (int b = 1; b < (1 << m); b++) begin
      if (gf_mul(m, a, 32'(b)) == 32'd1) return 32'(b);
    end
    return 32'd0;
  endfunction

endpackage

// File: rtl/berlekamp_inverter.sv
// Serial-input GF(2^M) inverter: the start pulse captures the MSB, the next M-1
// bits complete the operand, and standard_out holds the inverse until the next start.
module berlekamp_inverter
  import bch_serial_divider_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         start,
  input  logic         standard_in,
  output logic [M-1:0] standard_out
);

  localparam int CW = $clog2(M + 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(M);
  localparam logic [CW-1:0] CNT_IDLE = CW'(M + 1);

  logic [M-1:0]  shift_r;
  logic [CW-1:0] cnt_r;
  logic [M-1:0]  inv_r;

  // Bit capture and one-shot inversion; no reset, start reinitialises everything.
  always_ff @(posedge clk) begin
    if (start) begin
      shift_r <= {{(M-1){1'b0}}, standard_in};
      cnt_r   <= CNT_ONE;
    end else if (cnt_r < CNT_FULL) begin
      shift_r <= {shift_r[M-2:0], standard_in};
      cnt_r   <= cnt_r + CNT_ONE;
    end else if (cnt_r == CNT_FULL) begin
      inv_r <= M'(gf_inv(M, 32'(shift_r)));
      cnt_r <= CNT_IDLE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign standard_out = inv_r;

endmodule

// File: rtl/gf_serial_mult.sv
// MSB-first bit-serial standard-basis multiplier: load clears the accumulator and
// latches the operand, each step does acc = acc*alpha ^ (bit ? operand : 0).
module gf_serial_mult
  import bch_serial_divider_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic         step,
  input  logic         bit_in,
  input  logic [M-1:0] operand,
  output logic [M-1:0] acc_next
);

  logic [M-1:0] acc_r;
  logic [M-1:0] operand_r;
  logic [M-1:0] acc_next_s;

  // Next accumulator value, exposed so the caller can register the final product.
  always_comb begin
    acc_next_s = acc_r;
    if (load) begin
      acc_next_s = {M{1'b0}};
    end else if (step) begin
      acc_next_s = M'(mulx(M, 32'(acc_r))) ^ (bit_in ? operand_r : {M{1'b0}});
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Accumulator and operand storage.
  always_ff @(posedge clk) begin
    acc_r <= acc_next_s;
    if (load) begin
      operand_r <= operand;
    end else begin
      operand_r <= operand_r;
    end
  end

  assign acc_next = acc_next_s;

endmodule

// File: rtl/bch_serial_divider.sv
// Constant-latency GF(2^M) divider: serially inverts the divisor, then multiplies
// the inverse by the dividend bit-serially. Result appears 3M cycles after accept.
module bch_serial_divider
  import bch_serial_divider_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] quotient,
  output logic         div_zero
);

  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] CNT_ZERO       = CW'(0);
  localparam logic [CW-1:0] CNT_ONE        = CW'(1);
  localparam logic [CW-1:0] CNT_FEED_LAST  = CW'(M - 1);
  localparam logic [CW-1:0] CNT_FLUSH_LAST = CW'(M - 3);
  localparam logic [CW-1:0] CNT_MUL_LAST   = CW'(M);

  div_state_e    state_r;
  logic [M-1:0]  dividend_r;
  logic [M-1:0]  divisor_r;
  logic [M-1:0]  shift_r;
  logic          zero_r;
  logic [CW-1:0] cnt_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic [M-1:0]  quotient_r;
  logic          div_zero_r;

  logic          inv_start_s;
  logic          inv_in_s;
  logic [M-1:0]  inv_out_s;
  logic          mul_load_s;
  logic          mul_step_s;
  logic [M-1:0]  acc_next_s;

  // Datapath strobes decoded from the current state.
  always_comb begin
    inv_start_s = 1'b0;
    inv_in_s    = 1'b0;
    mul_load_s  = 1'b0;
    mul_step_s  = 1'b0;
    case (state_r)
      START: begin
        inv_start_s = 1'b1;
        inv_in_s    = divisor_r[M-1];
      end
      FEED: inv_in_s = shift_r[M-1];
      MUL: begin
        if (cnt_r == CNT_ZERO) begin
          mul_load_s = 1'b1;
        end else begin
          mul_step_s = 1'b1;
        end
      end
      default: inv_in_s = 1'b0;
    endcase
  end

  // shift_r serves twice: divisor bits for the inverter, then dividend bits for the multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      dividend_r  <= {M{1'b0}};
      divisor_r   <= {M{1'b0}};
      shift_r     <= {M{1'b0}};
      zero_r      <= 1'b0;
      cnt_r       <= CNT_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quotient_r  <= {M{1'b0}};
      div_zero_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dividend_r <= dividend;
            divisor_r  <= divisor;
            zero_r     <= (divisor == {M{1'b0}});
            in_ready_r <= 1'b0;
            state_r    <= START;
          end
        end
        START: begin
          shift_r <= divisor_r << 1;
          cnt_r   <= CNT_ZERO;
          state_r <= FEED;
        end
        FEED: begin
          shift_r <= shift_r << 1;
          if (cnt_r == CNT_FEED_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= FLUSH;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        FLUSH: begin
          if (cnt_r == CNT_FLUSH_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= MUL;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        MUL: begin
          if (cnt_r == CNT_ZERO) begin
            shift_r <= dividend_r;
            cnt_r   <= CNT_ONE;
          end else if (cnt_r == CNT_MUL_LAST) begin
            shift_r     <= shift_r << 1;
            out_valid_r <= 1'b1;
            quotient_r  <= zero_r ? {M{1'b0}} : acc_next_s;
            div_zero_r  <= zero_r;
            state_r     <= DONE;
          end else begin
            shift_r <= shift_r << 1;
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  berlekamp_inverter #(.M(M)) u_inverter (
    .clk          (clk),
    .start        (inv_start_s),
    .standard_in  (inv_in_s),
    .standard_out (inv_out_s)
  );

  gf_serial_mult #(.M(M)) u_mult (
    .clk      (clk),
    .load     (mul_load_s),
    .step     (mul_step_s),
    .bit_in   (shift_r[M-1]),
    .operand  (inv_out_s),
    .acc_next (acc_next_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign quotient  = quotient_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_bch_serial_divider.sv
// Directed bench for bch_serial_divider (M=8, poly 0x11D): hand vectors, a divisor
// sweep checked against an independent reference multiplier, backpressure and reset.
module tb_bch_serial_divider;

  localparam int M = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [M-1:0] dividend = 8'h00;
  logic [M-1:0] divisor = 8'h00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [M-1:0] quotient;
  logic         div_zero;

  int n_checks = 0;
  int n_pass = 0;

  bch_serial_divider #(.M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // LSB-first shift-and-add reference, deliberately unlike the DUT structure.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a);
    logic [7:0] c;
    for (int b = 1; b < 256; b++) begin
      c = 8'(b);
      if (ref_mul(a, c) == 8'h01) return c;
    end
    return 8'h00;
  endfunction

  // One complete transaction; operands are scrambled right after accept.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic dz, output int lat);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 8'hFF;
    divisor  = 8'hFF;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 60) check("timeout", 32'(lat), 32'd24);
    q  = quotient;
    dz = div_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] q;
    logic       dz;
    int         lat;
    logic [7:0] d;
    logic [7:0] a;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);

    run_div(8'h08, 8'h02, q, dz, lat);
    check("q_08_02", 32'(q), 32'h04);
    check("dz_08_02", 32'(dz), 32'd0);
    check("lat_08_02", 32'(lat), 32'd24);
    check("ready_after_release", 32'(in_ready), 32'd1);
    run_div(8'h20, 8'h04, q, dz, lat);
    check("q_20_04", 32'(q), 32'h08);
    run_div(8'h01, 8'h01, q, dz, lat);
    check("q_01_01", 32'(q), 32'h01);
    run_div(8'h01, 8'h02, q, dz, lat);
    check("q_01_02", 32'(q), 32'h8E);
    run_div(8'h37, 8'h00, q, dz, lat);
    check("q_div0", 32'(q), 32'h00);
    check("dz_div0", 32'(dz), 32'd1);
    check("lat_div0", 32'(lat), 32'd24);
    run_div(8'h00, 8'h53, q, dz, lat);
    check("q_zero_dividend", 32'(q), 32'h00);
    check("dz_zero_dividend", 32'(dz), 32'd0);

    // Every nonzero divisor alpha^i, i = 0..254.
    d = 8'h01;
    for (int i = 0; i < 255; i++) begin
      run_div(8'h01, d, q, dz, lat);
      check("sweep_inv", 32'(q), 32'(ref_inv(d)));
      run_div(d, d, q, dz, lat);
      check("sweep_self", 32'(q), 32'h01);
      run_div(8'h55, d, q, dz, lat);
      check("sweep_prod", 32'(ref_mul(q, d)), 32'h55);
      check("sweep_lat", 32'(lat), 32'd24);
      d = ref_mul(d, 8'h02);
    end

    // Backpressure with an ignored second request.
    dividend = 8'h08;
    divisor  = 8'h02;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd24);
    dividend = 8'h20;
    divisor  = 8'h04;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c >= 3 && c < 6);
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_quot", 32'(quotient), 32'h04);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    run_div(8'h20, 8'h04, q, dz, lat);
    check("bp_second_q", 32'(q), 32'h08);
    check("bp_second_lat", 32'(lat), 32'd24);

    // Reset in the middle of FEED.
    dividend = 8'h08;
    divisor  = 8'h02;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_quotient", 32'(quotient), 32'd0);
    check("mid_rst_div_zero", 32'(div_zero), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("mid_rst_no_output", 32'(out_valid), 32'd0);
    a = 8'h20;
    run_div(a, 8'h04, q, dz, lat);
    check("post_rst_q", 32'(q), 32'h08);
    check("post_rst_lat", 32'(lat), 32'd24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
